// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a reloadable LEN-bit pattern, overlap/non-overlap modes and sample gating.
// Optional saturating match counter on match_count, enabled by defining SEQDET_COUNT_EN.
module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           w,
  input  logic           mode,
  input  logic           cfg_we,
  input  logic [LEN-1:0] cfg_pattern,
  output logic           z
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam int             FW       = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN);

  logic [LEN-1:0] pat;
  logic [LEN-1:0] hist;
  logic [LEN-1:0] hist_n;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_n;
  logic [FW-1:0]  fill_d;
  logic           match;

  // fill counts valid history bits so a partially filled window can never match
  always_comb begin
    hist_n = (hist << 1) | LEN'(w);
    fill_n = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
    match  = en && !cfg_we && (fill_n == FILL_MAX) && (hist_n == pat);
    fill_d = (match && mode) ? '0 : fill_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (cfg_we) begin
      pat  <= cfg_pattern;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (en) begin
      hist <= hist_n;
      fill <= fill_d;
      z    <= match;
    end else begin
      z    <= 1'b0;
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || cfg_we) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus random stimulus against a queue-based window model.
// Build with SEQDET_COUNT_EN defined to also check match_count.
module tb_seq_detector_param;

  localparam int             LEN     = 4;
  localparam logic [LEN-1:0] PATTERN = 4'b1011;
  localparam int             CNT_W   = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           w;
  logic           mode;
  logic           cfg_we;
  logic [LEN-1:0] cfg_pattern;
  logic           z;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] match_count;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  seq_detector_param #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .w           (w),
    .mode        (mode),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .z           (z)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  // reference model: the bits sampled since the last clear, oldest first
  bit             bits_q[$];
  logic [LEN-1:0] pat_m;
  int             cnt_m;
  logic [0:0]     exp_q[$];
  int             n_vec;
  int             n_err;
  int             pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic ww, input logic md,
                            input logic we, input logic [LEN-1:0] cp);
    logic [LEN-1:0] v;
    logic           m;
    m = 1'b0;
    v = '0;
    if (r) begin
      pat_m = PATTERN;
      bits_q.delete();
      cnt_m = 0;
    end else if (we) begin
      pat_m = cp;
      bits_q.delete();
      cnt_m = 0;
    end else if (e) begin
      bits_q.push_back(ww);
      if (bits_q.size() > LEN) void'(bits_q.pop_front());
      if (bits_q.size() == LEN) begin
        foreach (bits_q[i]) v[LEN-1-i] = bits_q[i];
        m = (v == pat_m);
      end
      if (m) begin
        if (cnt_m < (2 ** CNT_W) - 1) cnt_m++;
        if (md) bits_q.delete();
      end
    end
    exp_q.push_back(m);
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic drive(input logic r, input logic e, input logic ww, input logic md,
                       input logic we, input logic [LEN-1:0] cp);
    reset       = r;
    en          = e;
    w           = ww;
    mode        = md;
    cfg_we      = we;
    cfg_pattern = cp;
    @(posedge clk);
    model_step(r, e, ww, md, we, cp);
    #1;
    check("z", {31'd0, z}, {31'd0, exp_q.pop_front()});
    if (z) pulses++;
`ifdef SEQDET_COUNT_EN
    check("match_count", {{(32-CNT_W){1'b0}}, match_count}, cnt_m);
`endif
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic md, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i], md, 1'b0, '0);
      repeat (gap) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), md, 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    pulses = 0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    pulses = 0;
    pat_m  = PATTERN;
    cnt_m  = 0;

    // T1: reset held with en=1,w=1, then three ones
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    pulses = 0;
    feed(16'b111, 3, 1'b0, 0);
    check("t1_pulses", pulses, 0);

    // T2: overlapping detection
    do_reset();
    feed(16'b1011011, 7, 1'b0, 0);
    check("t2_pulses", pulses, 2);

    // T3: non-overlapping detection
    do_reset();
    feed(16'b1011011, 7, 1'b1, 0);
    check("t3a_pulses", pulses, 1);
    do_reset();
    feed(16'b10111011, 8, 1'b1, 0);
    check("t3b_pulses", pulses, 2);

    // T4: two idle cycles between every sample
    do_reset();
    feed(16'b1011011, 7, 1'b0, 2);
    check("t4_pulses", pulses, 2);

    // T5: reload mid-stream drops the concurrent sample and the partial history
    do_reset();
    feed(16'b101, 3, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
    pulses = 0;
    feed(16'b11111, 5, 1'b0, 0);
    check("t5a_pulses", pulses, 2);
    do_reset();
    feed(16'b101, 3, 1'b0, 0);
    do_reset();
    feed(16'b1, 1, 1'b0, 0);
    check("t5b_pulses", pulses, 0);

`ifdef SEQDET_COUNT_EN
    // T6: counter saturates while z keeps pulsing
    do_reset();
    for (int k = 0; k < 5; k++) feed(16'b1011, 4, 1'b1, 0);
    check("t6_pulses", pulses, 5);
    check("t6_count", {{(32-CNT_W){1'b0}}, match_count}, 3);
`endif

    // randomized stimulus: rare resets and reloads, occasional mode flips, ~25% idle cycles
    do_reset();
    begin
      logic md;
      md = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 19) == 0) md = ~md;
        drive(1'($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              md,
              1'($urandom_range(0, 49) == 0),
              LEN'($urandom_range(0, (2 ** LEN) - 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
